// File: rtl/uart_pkg.sv
// Shared UART definitions for uart_rx and uart_tx.
// Contents: FSM state encoding, default line parameters, data width,
// and the clocks-per-bit helper.
package uart_pkg;

    localparam int unsigned STATE_W            = 3;
    localparam int unsigned DATA_W             = 8;
    localparam int unsigned DEFAULT_BAUD_RATE  = 9600;
    localparam int unsigned DEFAULT_CLOCK_FREQ = 50000000;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_state_e;

    // System clocks per serial bit (integer division).
    function automatic int unsigned clks_per_bit(input int unsigned clock_freq,
                                                 input int unsigned baud_rate);
        return clock_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: the serial line in and the received-byte outputs.
//   rx        serial line, idle high
//   data_out  last correctly received byte
//   valid     one-cycle pulse when data_out updates
//   frame_err one-cycle pulse on a low stop bit
//   busy      frame in progress or line held in break
// master = the receiver, slave = line driver / consumer.
interface uart_rx_if;
    import uart_pkg::*;

    logic              rx;
    logic [DATA_W-1:0] data_out;
    logic              valid;
    logic              frame_err;
    logic              busy;

    modport master (input rx, output data_out, output valid, output frame_err, output busy);
    modport slave  (output rx, input data_out, input valid, input frame_err, input busy);

endinterface

// File: rtl/uart_sync_2ff.sv
// Two-flop synchroniser for one asynchronous input.
//   clk, rst  clock and synchronous active-high reset
//   d         asynchronous input
//   q         synchronised output (two cycles of latency)
// RESET_VAL sets both flops on reset so an idle-high line reads idle.
module uart_sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver. Oversamples rx with clk, checks the start bit at
// mid-bit, samples data and stop bits one bit period apart (LSB first),
// and reports each frame with a one-cycle valid or frame_err pulse.
//   clk, rst  clock and synchronous active-high reset
//   bus       uart_rx_if.master: rx in; data_out/valid/frame_err/busy out
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_RATE  = DEFAULT_BAUD_RATE,
    parameter int unsigned CLOCK_FREQ = DEFAULT_CLOCK_FREQ
) (
    input  logic      clk,
    input  logic      rst,
    uart_rx_if.master bus
);

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLOCK_FREQ, BAUD_RATE);
    localparam int unsigned CNT_W        = 32;
    localparam int unsigned IDX_W        = 3;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_W - 1);

    if (CLKS_PER_BIT < 4) begin : g_bad_rate
        $error("uart_rx: CLOCK_FREQ / BAUD_RATE must be at least 4");
    end

    logic rx_s;

    uart_sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.rx),
        .q   (rx_s)
    );

    uart_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [IDX_W-1:0]  idx_q,   idx_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic              valid_q, valid_d;
    logic              ferr_q,  ferr_d;
    logic              busy_q,  busy_d;

    // State register and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s) state_d = START;
            end
            START: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        state_d = IDLE;   // glitch, not a start bit
                    end else begin
                        state_d = DATA;
                        idx_d   = '0;
                    end
                end
            end
            DATA: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Counter restarts at every bit boundary so each sample
                // lands one full bit after the previous mid-bit point.
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shreg_d = {rx_s, shreg_q[DATA_W-1:1]};
                    idx_d   = idx_q + IDX_W'(1);
                    if (idx_q == IDX_LAST) state_d = STOP;
                end
            end
            STOP: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Leave at mid-stop-bit so an immediate next start bit is seen.
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        data_d  = shreg_q;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = BREAK;
                    end
                end
            end
            BREAK: begin
                cnt_d = '0;
                if (rx_s) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign bus.data_out  = data_q;
    assign bus.valid     = valid_q;
    assign bus.frame_err = ferr_q;
    assign bus.busy      = busy_q;

endmodule
